// File: rtl/pc_sequencer.sv
// Purpose : program-counter sequencer; fetches, holds and retires one instruction at a time.
// Latency : 2 cycles per instruction minimum (FETCH with same-cycle ack, then one EXEC cycle).
// Backpr. : imem_req is held until imem_ack; stall freezes pc/instr while in EXEC.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   next_pc, stall        next-PC candidate and hazard hold, used in EXEC only
//   imem_req/addr/ack/rdata  instruction memory fetch handshake
//   pc, instr, instr_valid   architectural PC and held instruction for decode
//   halted, misalign_err, retired  status: stopped, sticky misaligned-target flag, retire count
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        stall,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] retired
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] retired_q, retired_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    retired_d  = retired_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // Acks are only meaningful here; any ack seen in another state is dropped.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (HALT_ON_ZERO && (instr_q == 32'h0)) begin
            // A zero word is not retired and leaves pc pointing at it.
            state_d = S_HALT;
          end else begin
            // Low bits are dropped so sequencing carries on word-aligned.
            pc_d      = {next_pc[31:2], 2'b00};
            retired_d = retired_q + 32'd1;
            if (next_pc[1:0] != 2'b00) misalign_d = 1'b1;
            state_d   = S_FETCH;
          end
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      misalign_q <= 1'b0;
      retired_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

  // Outputs decode straight from state so reset drops them without a clock edge.
  assign imem_req     = (state_q == S_FETCH);
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign instr_valid  = (state_q == S_EXEC);
  assign halted       = (state_q == S_HALT);
  assign misalign_err = misalign_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        stall = 1'b0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        misalign_err;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the architecture should show, per instruction.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  logic        m_misalign;
  logic        m_halted;

  pc_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .next_pc      (next_pc),
    .stall        (stall),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .halted       (halted),
    .misalign_err (misalign_err),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_instr    = 32'h0;
    m_retired  = 32'h0;
    m_misalign = 1'b0;
    m_halted   = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_pc"},       pc,           m_pc);
    check_eq({tag, "_retired"},  retired,      m_retired);
    check_eq({tag, "_misalign"}, misalign_err, {31'h0, m_misalign});
    check_eq({tag, "_halted"},   halted,       {31'h0, m_halted});
  endtask

  // Pulse reset from a falling edge; leaves the bench at the falling edge where FETCH begins.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    #1;
    model_reset();
    check_eq("rst_req",   imem_req,    32'h0);
    check_eq("rst_vld",   instr_valid, 32'h0);
    check_eq("rst_instr", instr,       32'h0);
    check_status("rst");
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("idle_req", imem_req,    32'h0);
    check_eq("idle_vld", instr_valid, 32'h0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // One instruction: fetch with ack_dly wait cycles, stall_n stalled EXEC cycles, then resolve with npc.
  task automatic run_instr(input logic [31:0] word, input int ack_dly, input int stall_n,
                           input logic [31:0] npc);
    check_eq("req_on",    imem_req,    32'h1);
    check_eq("fetch_adr", imem_addr,   m_pc);
    check_eq("vld_fetch", instr_valid, 32'h0);
    for (int d = 0; d <= ack_dly; d++) begin
      if (d > 0) begin
        check_eq("req_held",   imem_req,  32'h1);
        check_eq("adr_stable", imem_addr, m_pc);
        check_eq("instr_keep", instr,     m_instr);
      end
      imem_ack   = (d == ack_dly);
      imem_rdata = (d == ack_dly) ? word : $urandom;
      @(posedge clk);
      @(negedge clk);
    end
    imem_ack = 1'b0;
    m_instr  = word;
    check_eq("req_drop",  imem_req,    32'h0);
    check_eq("vld_exec",  instr_valid, 32'h1);
    check_eq("instr_cap", instr,       m_instr);
    check_eq("exec_pc",   pc,          m_pc);
    for (int s = 0; s < stall_n; s++) begin
      stall      = 1'b1;
      next_pc    = $urandom;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(posedge clk);
      @(negedge clk);
      check_eq("stall_pc",    pc,          m_pc);
      check_eq("stall_instr", instr,       m_instr);
      check_eq("stall_vld",   instr_valid, 32'h1);
    end
    stall    = 1'b0;
    imem_ack = 1'b0;
    next_pc  = npc;
    @(posedge clk);
    @(negedge clk);
    next_pc = $urandom;
    if (word == 32'h0) begin
      m_halted = 1'b1;
    end else begin
      m_pc       = npc & 32'hFFFF_FFFC;
      m_retired  = m_retired + 32'd1;
      m_misalign = m_misalign | (npc[1:0] != 2'b00);
    end
    check_status("retire");
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == 32'h0) w = 32'h1;
    return w;
  endfunction

  initial begin
    model_reset();
    #1;
    check_eq("por_req", imem_req, 32'h0);
    check_status("por");
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("first_idle_req", imem_req, 32'h0);
    @(posedge clk);
    @(negedge clk);

    // Same-cycle ack, next_pc = 4.
    run_instr(32'h2000_0001, 0, 0, 32'h4);
    // Ack delayed 3 cycles, then 5 stalled EXEC cycles with toggling next_pc.
    run_instr(rand_word(), 3, 5, 32'h0000_0040);
    // Misaligned target, then aligned traffic: flag must stay set.
    run_instr(rand_word(), 1, 0, 32'h0000_0106);
    check_eq("misalign_pc", pc, 32'h0000_0104);
    run_instr(rand_word(), 0, 1, 32'h0000_0200);
    check_eq("misalign_sticky", misalign_err, 32'h1);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] npc;
      npc = $urandom;
      if ($urandom_range(0, 3) != 0) npc[1:0] = 2'b00;
      run_instr(rand_word(), $urandom_range(0, 3), $urandom_range(0, 4), npc);
    end

    // Zero word halts; nothing afterwards may move the sequencer.
    run_instr(32'h0, 2, 1, 32'h0000_0800);
    for (int i = 0; i < 6; i++) begin
      stall      = 1'($urandom_range(0, 1));
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      next_pc    = $urandom;
      @(posedge clk);
      @(negedge clk);
      check_eq("halt_req", imem_req,    32'h0);
      check_eq("halt_vld", instr_valid, 32'h0);
      check_status("halt");
    end

    do_reset();

    // Retire count wraps from all-ones.
    dut.retired_q = 32'hFFFF_FFFF;
    m_retired     = 32'hFFFF_FFFF;
    run_instr(rand_word(), 0, 0, 32'h0000_0010);
    check_eq("wrap_zero", retired, 32'h0);
    run_instr(rand_word(), 1, 0, 32'h0000_0020);
    check_eq("wrap_one", retired, 32'h1);

    // Reset mid-fetch: request must fall before the next rising edge.
    check_eq("pre_rst_req", imem_req, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_req_drop", imem_req, 32'h0);
    model_reset();
    check_status("async_rst");
    // Late ack arrives during reset and in the IDLE cycle after release.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    check_eq("late_ack_instr", instr,     32'h0);
    check_eq("refetch_req",    imem_req,  32'h1);
    check_eq("refetch_adr",    imem_addr, 32'h0);
    run_instr(rand_word(), 0, 0, 32'h0000_0030);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
